// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I fetch stage.
package fetch_pkg;

  localparam int          DEPTH_DEFAULT = 2;
  localparam int          INST_W        = 32;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of {pc, inst} pairs between the memory response and decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge CLK) begin
    if (push && !RST && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch.sv
// RV32I fetch stage: sequential PC generation, credit-limited reads, redirect
// handling with stale-response dropping, and a small in-order output buffer.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_PC = 32'h0000_0000,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_EN,
  input  logic [31:0] BR_PC,
  output logic        INST_RDEN,
  output logic [31:0] INST_RDADDR,
  input  logic        INST_RDVALID,
  input  logic [31:0] INST_RDDATA,
  output logic [31:0] I_PC,
  output logic [31:0] I_INST,
  output logic        I_VALID
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic          issue;
  logic          resp_live;
  logic          push;
  logic [CW:0]   drop_sum;
  logic [CW-1:0] drop_next;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign issue     = !RST && !BR_EN &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
  assign resp_live = INST_RDVALID && (drop_cnt == '0);
  assign push      = resp_live && !BR_EN;

  assign INST_RDEN   = issue;
  assign INST_RDADDR = fetch_pc;
  assign I_VALID     = (fifo_count != '0) && !STALL && !BR_EN;
  assign I_PC        = head.pc;
  assign I_INST      = head.inst;
  assign push_entry  = '{pc: resp_pc, inst: INST_RDDATA};

  // On a redirect every live read becomes stale; a response arriving in the
  // same cycle retires one of them, whichever stream it belonged to.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + {1'b0, outstanding};
    if (INST_RDVALID && (drop_sum != '0)) begin
      drop_sum = drop_sum - 1'b1;
    end
    drop_next = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
  end

  // outstanding counts only reads of the current stream, so credit for the
  // redirect target is available immediately while stale reads drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= START_PC;
      resp_pc     <= START_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (BR_EN) begin
      fetch_pc    <= align_pc(BR_PC);
      resp_pc     <= align_pc(BR_PC);
      outstanding <= '0;
      drop_cnt    <= drop_next;
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_INC;
      if (push)  resp_pc  <= resp_pc + PC_INC;
      if (INST_RDVALID && !resp_live) drop_cnt <= drop_cnt - 1'b1;
      case ({issue, resp_live})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_data(push_entry),
    .pop      (I_VALID),
    .flush    (BR_EN),
    .head     (head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: behavioural memory with epoch-tagged requests and a
// scoreboard of expected {pc, inst} presentations.
module tb_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        BR_EN = 1'b0;
  logic [31:0] BR_PC = 32'h0;
  logic        INST_RDEN;
  logic [31:0] INST_RDADDR;
  logic        INST_RDVALID = 1'b0;
  logic [31:0] INST_RDDATA = 32'h0;
  logic [31:0] I_PC;
  logic [31:0] I_INST;
  logic        I_VALID;

  always #5 CLK = ~CLK;

  fetch #(
    .START_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STALL       (STALL),
    .BR_EN       (BR_EN),
    .BR_PC       (BR_PC),
    .INST_RDEN   (INST_RDEN),
    .INST_RDADDR (INST_RDADDR),
    .INST_RDVALID(INST_RDVALID),
    .INST_RDDATA (INST_RDDATA),
    .I_PC        (I_PC),
    .I_INST      (I_INST),
    .I_VALID     (I_VALID)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        br_en;
    logic [31:0] br_pc;
    logic        rden;
    logic [31:0] rdaddr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  mem_req_t    pending[$];
  exp_t        exp_q[$];
  logic [31:0] issued[$];
  vec_t        vecs[7];

  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  bit          nop_mode = 1'b1;
  logic [31:0] exp_fetch_pc = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        last_valid;
  logic        last_rden;
  logic [31:0] last_rdaddr;
  logic [31:0] last_pc;
  logic [31:0] last_inst;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return nop_mode ? NOP_INST : (addr ^ 32'hC0DE_0000);
  endfunction

  function automatic int liveCount();
    int n = 0;
    foreach (pending[i]) if (pending[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock of stimulus: drive inputs and memory at negedge, compare the
  // settled outputs against the scoreboard, then advance the model.
  task automatic applyStimulus(input logic stall, input logic br_en, input logic [31:0] br_pc);
    logic     resp;
    logic     exp_rden;
    logic     exp_valid;
    mem_req_t rq;
    @(negedge CLK);
    RST   = 1'b0;
    STALL = stall;
    BR_EN = br_en;
    BR_PC = br_pc;
    resp  = (pending.size() > 0) && (pending[0].due <= cyc);
    if (resp) begin
      rq           = pending[0];
      INST_RDVALID = 1'b1;
      INST_RDDATA  = memData(rq.addr);
    end else begin
      INST_RDVALID = 1'b0;
      INST_RDDATA  = $urandom;
    end
    #1;
    exp_rden  = !br_en && ((liveCount() + exp_q.size()) < DEPTH);
    exp_valid = (exp_q.size() != 0) && !stall && !br_en;
    checkOutput("rden", INST_RDEN, exp_rden);
    if (exp_rden) checkOutput("rdaddr", INST_RDADDR, exp_fetch_pc);
    checkOutput("i_valid", I_VALID, exp_valid);
    if (exp_q.size() != 0) begin
      checkOutput("i_pc", I_PC, exp_q[0].pc);
      checkOutput("i_inst", I_INST, exp_q[0].inst);
    end else begin
      checkOutput("i_pc_empty", I_PC, 32'h0);
      checkOutput("i_inst_empty", I_INST, 32'h0);
    end
    last_valid  = I_VALID;
    last_rden   = INST_RDEN;
    last_rdaddr = INST_RDADDR;
    last_pc     = I_PC;
    last_inst   = I_INST;

    if (resp) rq = pending.pop_front();
    if (INST_RDEN === 1'b1) begin
      pending.push_back(mem_req_t'{addr: INST_RDADDR, due: cyc + lat, epoch: epoch});
      issued.push_back(INST_RDADDR);
    end
    if (exp_valid) void'(exp_q.pop_front());
    if (br_en) begin
      exp_q.delete();
      epoch++;
      exp_fetch_pc = {br_pc[31:2], 2'b00};
    end else begin
      if (exp_rden) exp_fetch_pc += 32'd4;
      if (resp && (rq.epoch == epoch)) begin
        checkOutput("fifo_room", exp_q.size() < DEPTH, 1'b1);
        exp_q.push_back(exp_t'{pc: rq.addr, inst: INST_RDDATA});
      end
    end
    cyc++;
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST          = 1'b1;
    STALL        = 1'b0;
    BR_EN        = 1'b0;
    INST_RDVALID = 1'b0;
    @(negedge CLK);
    #1;
    checkOutput("rst_rden", INST_RDEN, 1'b0);
    checkOutput("rst_rdaddr", INST_RDADDR, 32'h0);
    checkOutput("rst_valid", I_VALID, 1'b0);
    checkOutput("rst_pc", I_PC, 32'h0);
    checkOutput("rst_inst", I_INST, 32'h0);
    pending.delete();
    exp_q.delete();
    epoch++;
    exp_fetch_pc = 32'h0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && pending.size() != 0; k++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain_idle", pending.size(), 32'd0);
  endtask

  task automatic waitValid(input string name, input logic [31:0] pc,
                           input logic [31:0] inst, input int budget);
    int n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end while (!last_valid && n < budget);
    checkOutput({name, "_valid"}, last_valid, 1'b1);
    checkOutput({name, "_pc"}, last_pc, pc);
    checkOutput({name, "_inst"}, last_inst, inst);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // stall br br_pc | rden rdaddr valid pc   (latency 1, cycles after RST falls)
    vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h08, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h4};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h8};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC};

    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].br_en, vecs[i].br_pc);
      checkOutput($sformatf("vec%0d_rden", i), last_rden, vecs[i].rden);
      checkOutput($sformatf("vec%0d_rdaddr", i), last_rdaddr, vecs[i].rdaddr);
      checkOutput($sformatf("vec%0d_valid", i), last_valid, vecs[i].valid);
      checkOutput($sformatf("vec%0d_pc", i), last_pc, vecs[i].pc);
    end

    // Stall while 0x10 is at the head: bubbles, then 0x10 and 0x14 in order.
    for (int k = 0; k < 20 && !(exp_q.size() > 0 && exp_q[0].pc == 32'h10); k++)
      applyStimulus(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_valid", last_valid, 1'b0);
      checkOutput("stall_head", last_pc, 32'h10);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("unstall0_valid", last_valid, 1'b1);
    checkOutput("unstall0_pc", last_pc, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("unstall1_valid", last_valid, 1'b1);
    checkOutput("unstall1_pc", last_pc, 32'h14);

    // Latency 3, two reads in flight to 0x20/0x24, then redirect to 0x100.
    drain();
    nop_mode = 1'b0;
    lat      = 3;
    applyStimulus(1'b1, 1'b1, 32'h20);
    for (int k = 0; k < 20 && liveCount() < 2; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("inflight_last", issued[issued.size()-1], 32'h24);
    applyStimulus(1'b0, 1'b1, 32'h100);
    waitValid("br_target", 32'h100, 32'h100 ^ 32'hC0DE_0000, 20);

    // Redirect coinciding with a response, misaligned target.
    for (int k = 0; k < 20 && !(pending.size() > 0 && pending[0].due <= cyc); k++)
      applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h203);
    waitValid("misaligned", 32'h200, 32'h200 ^ 32'hC0DE_0000, 20);

    // PC wrap at the top of the address space.
    drain();
    lat = 1;
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
    issued.delete();
    for (int k = 0; k < 20 && issued.size() < 3; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_count", issued.size() >= 3, 1'b1);
    if (issued.size() >= 3) begin
      checkOutput("wrap0", issued[0], 32'hFFFF_FFF8);
      checkOutput("wrap1", issued[1], 32'hFFFF_FFFC);
      checkOutput("wrap2", issued[2], 32'h0000_0000);
    end

    // Redirect together with STALL on a full buffer.
    for (int k = 0; k < 40 && !(exp_q.size() == DEPTH && pending.size() == 0); k++)
      applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("full_head_visible", last_pc, exp_q.size() > 0 ? exp_q[0].pc : 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 32'h300);
    checkOutput("br_stall_valid", last_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("flushed_pc", last_pc, 32'h0);
    waitValid("br_stall_target", 32'h300, 32'h300 ^ 32'hC0DE_0000, 20);

    // Mid-run reset with the memory idle.
    drain();
    doReset();
    waitValid("post_reset", 32'h0, 32'h0 ^ 32'hC0DE_0000, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
